// File: rtl/persiana_pkg.sv
// Shared types and defaults for the blind actuator model and the FSM_Persianas benches.
// Holds state codes, direction constants and the default position geometry.
package persiana_pkg;

    typedef enum logic [2:0] {
        PARADO   = 3'd0,
        SUBIENDO = 3'd1,
        BAJANDO  = 3'd2,
        PAUSA    = 3'd3,
        FALLA    = 3'd4
    } estado_t;

    localparam logic SUBE = 1'b1;
    localparam logic BAJA = 1'b0;

    localparam int POS_MAX_DEF  = 200;
    localparam int POS_MED_DEF  = 100;
    localparam int SENS_WIN_DEF = 2;

    // True when p lies within centro +/- semi (inclusive).
    function automatic logic en_ventana(input logic [7:0] p, input int centro, input int semi);
        return (int'(p) >= centro - semi) && (int'(p) <= centro + semi);
    endfunction

endpackage

// File: rtl/persiana_prescaler.sv
// Free-running divider: one-cycle tick every PRESC_DIV clocks.
// Counts 0..PRESC_DIV-1 and raises tick on the last count.
module persiana_prescaler #(
    parameter int PRESC_DIV = 1_000_000
) (
    input  logic clk,
    input  logic reseteo,
    output logic tick
);

    localparam int CW = $clog2(PRESC_DIV);

    logic [CW-1:0] cuenta;

    assign tick = (cuenta == CW'(PRESC_DIV - 1));

    always_ff @(posedge clk or posedge reseteo) begin
        if (reseteo) begin
            cuenta <= '0;
        end else if (tick) begin
            cuenta <= '0;
        end else begin
            cuenta <= cuenta + CW'(1);
        end
    end

endmodule

// File: rtl/persiana_actuador_modelo.sv
// Plant model of the blind: integrates position from subir/bajar motor commands
// and produces the Ssup/Smed/Sinf sensors read back by the blind controller.
module persiana_actuador_modelo
    import persiana_pkg::*;
#(
    parameter int PRESC_DIV  = 1_000_000,
    parameter int POS_MAX    = POS_MAX_DEF,
    parameter int POS_MED    = POS_MED_DEF,
    parameter int SENS_WIN   = SENS_WIN_DEF,
    parameter int POS_INI    = 0,
    parameter int DEAD_TICKS = 5
) (
    input  logic       clk,
    input  logic       reseteo,
    input  logic       subir,
    input  logic       bajar,
    output logic       Ssup,
    output logic       Smed,
    output logic       Sinf,
    output logic [7:0] pos,
    output logic       moviendo,
    output logic       falla,
    output logic [2:0] estado
);

    localparam logic [7:0] TOPE = 8'(POS_MAX);
    localparam int         DW   = $clog2(DEAD_TICKS + 1);
    localparam logic [DW-1:0] MUERTO_FIN = DW'(DEAD_TICKS);

    logic          sub_m, baj_m, s_sub, s_baj;
    logic          tick;
    estado_t       est_q, est_d;
    logic [7:0]    pos_q, pos_d;
    logic [DW-1:0] muerto_q, muerto_d, muerto_inc;
    logic          dir_q, dir_d;

    persiana_prescaler #(.PRESC_DIV(PRESC_DIV)) u_presc (
        .clk     (clk),
        .reseteo (reseteo),
        .tick    (tick)
    );

    // Two-flop synchronisers for the asynchronous motor commands.
    always_ff @(posedge clk or posedge reseteo) begin
        if (reseteo) begin
            sub_m <= 1'b0;
            s_sub <= 1'b0;
            baj_m <= 1'b0;
            s_baj <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage samples the previous stage's pre-edge value.
            sub_m <= subir;
            s_sub <= sub_m;
            baj_m <= bajar;
            s_baj <= baj_m;
        end
    end

    always_ff @(posedge clk or posedge reseteo) begin
        if (reseteo) begin
            est_q    <= PARADO;
            pos_q    <= 8'(POS_INI);
            muerto_q <= '0;
            dir_q    <= BAJA;
        end else begin
            est_q    <= est_d;
            pos_q    <= pos_d;
            muerto_q <= muerto_d;
            dir_q    <= dir_d;
        end
    end

    assign muerto_inc = muerto_q + DW'(1);

    // Branch order encodes priority: fault > end-stop > release > reversal > step.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        est_d    = est_q;
        pos_d    = pos_q;
        muerto_d = muerto_q;
        dir_d    = dir_q;
        case (est_q)
            PARADO: begin
                if (s_sub && s_baj)                est_d = FALLA;
                else if (s_sub && pos_q != TOPE)   est_d = SUBIENDO;
                else if (s_baj && pos_q != 8'd0)   est_d = BAJANDO;
            end
            SUBIENDO: begin
                if (s_sub && s_baj) begin
                    est_d = FALLA;
                end else if (tick && pos_q >= TOPE - 8'd1) begin
                    pos_d = TOPE;
                    est_d = PARADO;
                end else if (!s_sub && !s_baj) begin
                    est_d = PARADO;
                end else if (s_baj) begin
                    est_d    = PAUSA;
                    dir_d    = BAJA;
                    muerto_d = '0;
                end else if (tick) begin
                    pos_d = pos_q + 8'd1;
                end
            end
            BAJANDO: begin
                if (s_sub && s_baj) begin
                    est_d = FALLA;
                end else if (tick && pos_q <= 8'd1) begin
                    pos_d = 8'd0;
                    est_d = PARADO;
                end else if (!s_sub && !s_baj) begin
                    est_d = PARADO;
                end else if (s_sub) begin
                    est_d    = PAUSA;
                    dir_d    = SUBE;
                    muerto_d = '0;
                end else if (tick) begin
                    pos_d = pos_q - 8'd1;
                end
            end
            PAUSA: begin
                if (s_sub && s_baj) begin
                    est_d = FALLA;
                end else if (!s_sub && !s_baj) begin
                    est_d = PARADO;
                end else if (tick) begin
                    muerto_d = muerto_inc;
                    if (muerto_inc == MUERTO_FIN) begin
                        if (dir_q == SUBE && s_sub && pos_q != TOPE)       est_d = SUBIENDO;
                        else if (dir_q == BAJA && s_baj && pos_q != 8'd0)  est_d = BAJANDO;
                        else                                               est_d = PARADO;
                    end
                end
            end
            FALLA: begin
                if (!s_sub && !s_baj) est_d = PARADO;
            end
            default: est_d = PARADO;
        endcase
    end

    assign pos      = pos_q;
    assign estado   = est_q;
    assign moviendo = (est_q == SUBIENDO) || (est_q == BAJANDO);
    assign falla    = (est_q == FALLA);
    assign Ssup     = (pos_q == TOPE);
    assign Sinf     = (pos_q == 8'd0);
    assign Smed     = en_ventana(pos_q, POS_MED, SENS_WIN);

endmodule
